// File: rtl/div_sched_pkg.sv
// div_sched shared definitions: state encoding, default widths,
// timeout and result slice positions for the divider sequencer.
package div_sched_pkg;

    localparam int REG_WIDTH        = 32;
    localparam int DOUBLE_REG_WIDTH = 2 * REG_WIDTH;
    localparam int DIV_TIMEOUT      = 48;

    // Quotient sits at the bottom of the divider result,
    // the remainder directly above it (offset DATA_W).
    localparam int QUOT_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_sched_cache.sv
// Last-result cache for div_sched (built only with DIV_SCHED_CACHE_EN).
// Ports: fill_* store a finished divide; dividend/divisor/signed_i look up, hit_o/result_o answer.
module div_sched_cache
    import div_sched_pkg::*;
#(
    parameter int DATA_W = REG_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fill_i,
    input  logic [DATA_W-1:0]   fill_dividend_i,
    input  logic [DATA_W-1:0]   fill_divisor_i,
    input  logic                fill_signed_i,
    input  logic [2*DATA_W-1:0] fill_result_i,
    input  logic [DATA_W-1:0]   dividend_i,
    input  logic [DATA_W-1:0]   divisor_i,
    input  logic                signed_i,
    output logic                hit_o,
    output logic [2*DATA_W-1:0] result_o
);

    logic                valid_q;
    logic [DATA_W-1:0]   dividend_q;
    logic [DATA_W-1:0]   divisor_q;
    logic                signed_q;
    logic [2*DATA_W-1:0] result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            result_q   <= '0;
        end else if (fill_i) begin
            valid_q    <= 1'b1;
            dividend_q <= fill_dividend_i;
            divisor_q  <= fill_divisor_i;
            signed_q   <= fill_signed_i;
            result_q   <= fill_result_i;
        end
    end

    assign hit_o = valid_q
                 & (dividend_i == dividend_q)
                 & (divisor_i == divisor_q)
                 & (signed_i == signed_q);

    assign result_o = result_q;

endmodule

// File: rtl/div_sched.sv
// Sequencer between EX and the shared iterative divider; optional cache via DIV_SCHED_CACHE_EN.
// Ports: EX request/operands in, pause/result/err out; div start/cancel/signed/data out, result/done in.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int DATA_W  = REG_WIDTH,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                signed_i,
    input  logic                sel_rem_i,
    input  logic [DATA_W-1:0]   dividend_i,
    input  logic [DATA_W-1:0]   divisor_i,
    input  logic                flush_i,
    input  logic                ex_stall_i,
    output logic                pause_ex_o,
    output logic [DATA_W-1:0]   result_o,
    output logic                result_valid_o,
    output logic                err_o,
    output logic                div_start_o,
    output logic                div_cancel_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_data1_o,
    output logic [DATA_W-1:0]   div_data2_o,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_done_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    div_state_e        state;
    logic [DATA_W-1:0] dividend_q;
    logic [DATA_W-1:0] divisor_q;
    logic              signed_q;
    logic              sel_rem_q;
    logic [DATA_W-1:0] result_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              busy;
    logic              timeout_hit;
    logic [DATA_W-1:0] done_sel;
    logic              hit;
    logic [DATA_W-1:0] hit_res;

    assign busy = (state == S_BUSY);

    // done and flush both outrank the timeout abort
    assign timeout_hit = busy & ~flush_i & ~div_done_i
                       & (cnt_q == CNT_W'(TIMEOUT - 1));

    assign done_sel = sel_rem_q ? div_result_i[DATA_W +: DATA_W]
                                : div_result_i[QUOT_LSB +: DATA_W];

`ifdef DIV_SCHED_CACHE_EN
    logic              fill;
    logic [2*DATA_W-1:0] hit_full;

    // only a genuine divider completion is worth remembering
    assign fill = busy & ~flush_i & div_done_i;

    div_sched_cache #(
        .DATA_W(DATA_W)
    ) u_cache (
        .clk             (clk),
        .rst             (rst),
        .fill_i          (fill),
        .fill_dividend_i (dividend_q),
        .fill_divisor_i  (divisor_q),
        .fill_signed_i   (signed_q),
        .fill_result_i   (div_result_i),
        .dividend_i      (dividend_i),
        .divisor_i       (divisor_i),
        .signed_i        (signed_i),
        .hit_o           (hit),
        .result_o        (hit_full)
    );

    // half chosen by the new request, so div/mod pairs share one divide
    assign hit_res = sel_rem_i ? hit_full[DATA_W +: DATA_W]
                               : hit_full[QUOT_LSB +: DATA_W];
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            sel_rem_q  <= 1'b0;
            result_q   <= '0;
            cnt_q      <= '0;
        end else if (flush_i) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_i) begin
                        dividend_q <= dividend_i;
                        divisor_q  <= divisor_i;
                        signed_q   <= signed_i;
                        sel_rem_q  <= sel_rem_i;
                        cnt_q      <= '0;
                        if (divisor_i == '0) begin
                            state <= S_ZERO;
                        end else if (hit) begin
                            result_q <= hit_res;
                            state    <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (div_done_i) begin
                        result_q <= done_sel;
                        state    <= S_DONE;
                    end else if (timeout_hit) begin
                        result_q <= '1;
                        state    <= S_DONE;
                    end
                end
                S_ZERO: begin
                    result_q <= sel_rem_q ? dividend_q : '1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (!ex_stall_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign pause_ex_o     = req_i & ~flush_i & (state != S_DONE);
    assign result_valid_o = (state == S_DONE);
    assign result_o       = result_q;
    assign err_o          = timeout_hit;
    assign div_start_o    = busy & ~flush_i;
    assign div_cancel_o   = busy & (flush_i | timeout_hit);
    assign div_signed_o   = signed_q;
    assign div_data1_o    = dividend_q;
    assign div_data2_o    = divisor_q;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed cases plus random divides
// against an arithmetic reference; bench plays the divider.
module tb_div_sched;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int TMO = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        signed_i;
    logic        sel_rem_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic        ex_stall_i;
    logic        pause_ex_o;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        err_o;
    logic        div_start_o;
    logic        div_cancel_o;
    logic        div_signed_o;
    logic [31:0] div_data1_o;
    logic [31:0] div_data2_o;
    logic [63:0] div_result_i;
    logic        div_done_i;

    int tests = 0;
    int fails = 0;

`ifdef DIV_SCHED_CACHE_EN
    bit          c_valid = 1'b0;
    logic [31:0] c_a;
    logic [31:0] c_b;
    logic        c_s;
`endif

    div_sched dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .signed_i       (signed_i),
        .sel_rem_i      (sel_rem_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .flush_i        (flush_i),
        .ex_stall_i     (ex_stall_i),
        .pause_ex_o     (pause_ex_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .err_o          (err_o),
        .div_start_o    (div_start_o),
        .div_cancel_o   (div_cancel_o),
        .div_signed_o   (div_signed_o),
        .div_data1_o    (div_data1_o),
        .div_data2_o    (div_data2_o),
        .div_result_i   (div_result_i),
        .div_done_i     (div_done_i)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // full divider answer {remainder, quotient}, plus the divide-by-zero rule
    function automatic logic [63:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic run_div(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic s,
                           input logic rem, input int lat, input int stall,
                           input logic [31:0] exp);
        logic [63:0] full;
        int path;
        int pcnt;
        int pexp;
        full = ref_div(a, b, s);
        path = (b == 32'd0) ? 1 : 0;
`ifdef DIV_SCHED_CACHE_EN
        if (path == 0 && c_valid && c_a == a && c_b == b && c_s == s)
            path = 2;
`endif
        pexp = (path == 0) ? lat + 1 : (path == 1) ? 2 : 1;
        pcnt = 0;
        req_i = 1'b1;
        dividend_i = a;
        divisor_i = b;
        signed_i = s;
        sel_rem_i = rem;
        #1;
        chk1({tag, "/pause0"}, pause_ex_o, 1'b1);
        chk1({tag, "/valid0"}, result_valid_o, 1'b0);
        chk1({tag, "/start0"}, div_start_o, 1'b0);
        if (pause_ex_o) pcnt++;
        tick;
        if (path == 0) begin
            for (int k = 1; k <= lat; k++) begin
                dividend_i = $urandom;
                divisor_i = $urandom;
                if (k == lat) begin
                    div_done_i = 1'b1;
                    div_result_i = full;
                end
                #1;
                if (k == 1 || k == lat) begin
                    chk1({tag, "/start"}, div_start_o, 1'b1);
                    chk32({tag, "/data1"}, div_data1_o, a);
                    chk32({tag, "/data2"}, div_data2_o, b);
                    chk1({tag, "/signed"}, div_signed_o, s);
                    chk1({tag, "/cancel"}, div_cancel_o, 1'b0);
                end
                if (pause_ex_o) pcnt++;
                tick;
            end
            div_done_i = 1'b0;
            div_result_i = {$urandom, $urandom};
`ifdef DIV_SCHED_CACHE_EN
            c_valid = 1'b1;
            c_a = a;
            c_b = b;
            c_s = s;
`endif
        end else if (path == 1) begin
            #1;
            chk1({tag, "/zstart"}, div_start_o, 1'b0);
            if (pause_ex_o) pcnt++;
            tick;
        end
        #1;
        chk32({tag, "/pausecnt"}, pcnt, pexp);
        chk1({tag, "/valid"}, result_valid_o, 1'b1);
        chk32({tag, "/result"}, result_o, exp);
        chk1({tag, "/startd"}, div_start_o, 1'b0);
        for (int j = 0; j < stall; j++) begin
            ex_stall_i = 1'b1;
            tick;
            #1;
            chk1({tag, "/stallv"}, result_valid_o, 1'b1);
            chk32({tag, "/stallr"}, result_o, exp);
        end
        ex_stall_i = 1'b0;
        tick;
        req_i = 1'b0;
        #1;
        chk1({tag, "/idlev"}, result_valid_o, 1'b0);
        chk1({tag, "/idlep"}, pause_ex_o, 1'b0);
        tick;
    endtask

    task automatic run_flush(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input int at,
                             input logic with_done);
        req_i = 1'b1;
        dividend_i = a;
        divisor_i = b;
        signed_i = 1'b0;
        sel_rem_i = 1'b0;
        tick;
        for (int k = 1; k < at; k++) tick;
        flush_i = 1'b1;
        if (with_done) begin
            div_done_i = 1'b1;
            div_result_i = ref_div(a, b, 1'b0);
        end
        #1;
        chk1({tag, "/cancel"}, div_cancel_o, 1'b1);
        chk1({tag, "/start"}, div_start_o, 1'b0);
        chk1({tag, "/pause"}, pause_ex_o, 1'b0);
        tick;
        flush_i = 1'b0;
        div_done_i = 1'b0;
        req_i = 1'b0;
        #1;
        chk1({tag, "/valid"}, result_valid_o, 1'b0);
        chk1({tag, "/cancel1"}, div_cancel_o, 1'b0);
        chk1({tag, "/start1"}, div_start_o, 1'b0);
        tick;
        #1;
        chk1({tag, "/valid2"}, result_valid_o, 1'b0);
        tick;
    endtask

    task automatic run_timeout(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic rem);
        req_i = 1'b1;
        dividend_i = a;
        divisor_i = b;
        signed_i = 1'b0;
        sel_rem_i = rem;
        tick;
        for (int k = 0; k < TMO; k++) begin
            #1;
            if (k == TMO - 1) begin
                chk1({tag, "/err"}, err_o, 1'b1);
                chk1({tag, "/cancel"}, div_cancel_o, 1'b1);
            end else if (k == 0 || k == TMO - 2) begin
                chk1({tag, "/err_early"}, err_o, 1'b0);
                chk1({tag, "/cancel_early"}, div_cancel_o, 1'b0);
            end
            tick;
        end
        #1;
        chk1({tag, "/valid"}, result_valid_o, 1'b1);
        chk32({tag, "/result"}, result_o, 32'hFFFF_FFFF);
        chk1({tag, "/err_after"}, err_o, 1'b0);
        chk1({tag, "/cancel_after"}, div_cancel_o, 1'b0);
        tick;
        req_i = 1'b0;
        #1;
        chk1({tag, "/idle"}, result_valid_o, 1'b0);
        tick;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        rem;
        logic [31:0] pa;
        logic [31:0] pb;
        logic        ps;
        logic [63:0] full;

        rst = 1'b1;
        req_i = 1'b0;
        signed_i = 1'b0;
        sel_rem_i = 1'b0;
        dividend_i = '0;
        divisor_i = '0;
        flush_i = 1'b0;
        ex_stall_i = 1'b0;
        div_result_i = '0;
        div_done_i = 1'b0;
        tick;
        tick;
        chk1("rst/pause", pause_ex_o, 1'b0);
        chk1("rst/valid", result_valid_o, 1'b0);
        chk32("rst/result", result_o, 32'd0);
        chk1("rst/err", err_o, 1'b0);
        chk1("rst/start", div_start_o, 1'b0);
        chk1("rst/cancel", div_cancel_o, 1'b0);
        chk32("rst/data1", div_data1_o, 32'd0);
        chk32("rst/data2", div_data2_o, 32'd0);
        rst = 1'b0;
        tick;

        run_div("u100d7q", 32'd100, 32'd7, 1'b0, 1'b0, 33, 0, 32'd14);
        run_div("u100d7r", 32'd100, 32'd7, 1'b0, 1'b1, 33, 0, 32'd2);
        run_div("s-7d2q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 20, 0,
                32'hFFFF_FFFD);
        run_div("s-7d2r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 20, 0,
                32'hFFFF_FFFF);
        run_div("z5q", 32'd5, 32'd0, 1'b0, 1'b0, 0, 0, 32'hFFFF_FFFF);
        run_div("z5r", 32'd5, 32'd0, 1'b0, 1'b1, 0, 0, 32'd5);
        run_div("stall5", 32'd1000, 32'd9, 1'b0, 1'b0, 12, 5, 32'd111);
        run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5, 0,
                32'h8000_0000);
        run_flush("flush10", 32'd123456, 32'd789, 10, 1'b0);
        run_flush("flushdone", 32'd654321, 32'd987, 6, 1'b1);
        run_timeout("tmo", 32'h0000_DEAD, 32'h0000_1234, 1'b1);

        pa = 32'd100;
        pb = 32'd7;
        ps = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = pa;
                b = pb;
                s = ps;
            end else begin
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = $urandom_range(1, 300);
                    default: b = $urandom;
                endcase
                s = 1'($urandom_range(0, 1));
            end
            rem = 1'($urandom_range(0, 1));
            full = ref_div(a, b, s);
            run_div("rand", a, b, s, rem, $urandom_range(1, 40),
                    $urandom_range(0, 3), rem ? full[63:32] : full[31:0]);
            if (b != 32'd0) begin
                pa = a;
                pb = b;
                ps = s;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
